// File: rtl/ling_serial_subtractor_pkg.sv
// rtl/ling_serial_subtractor_pkg.sv - shared state encoding and slice width for the serial add/sub engine
package ling_serial_subtractor_pkg;

    localparam int SLICE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ling_serial_subtractor_ling8_cin_slice.sv
// rtl/ling_serial_subtractor_ling8_cin_slice.sv - 8-bit Ling adder slice with carry-in
module ling8_cin_slice
    import ling_serial_subtractor_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    logic [SLICE_W-1:0] g;
    logic [SLICE_W-1:0] p;
    logic [SLICE_W-1:0] x;
    logic [SLICE_W-1:0] h;

    assign g = a & b;
    assign p = a | b;
    assign x = a ^ b;

    // Ling pseudo-carry h[i] = g[i] | c[i-1]; the real carry is c[i] = p[i] & h[i].
    // cin plays the role of c[-1], so it folds straight into the bit-0 term.
    always_comb begin
        h    = '0;
        h[0] = g[0] | cin;
        for (int i = 1; i < SLICE_W; i++) begin
            h[i] = g[i] | (p[i-1] & h[i-1]);
        end
    end

    assign sum[0]           = x[0] ^ cin;
    assign sum[SLICE_W-1:1] = x[SLICE_W-1:1] ^ (p[SLICE_W-2:0] & h[SLICE_W-2:0]);
    assign cout             = p[SLICE_W-1] & h[SLICE_W-1];

endmodule

// File: rtl/ling_serial_subtractor.sv
// rtl/ling_serial_subtractor.sv - multi-cycle add/subtract engine reusing one Ling slice per cycle
module ling_serial_subtractor
    import ling_serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_c,
    output logic             flag_v
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic               carry;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic               op_is_sub;

    logic [WIDTH-1:0]   b_adj;
    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;
    logic               sign_a;
    logic               sign_b;

    assign b_adj   = op_is_sub ? ~op_b : op_b;
    assign slice_a = op_a[idx*SLICE_W +: SLICE_W];
    assign slice_b = b_adj[idx*SLICE_W +: SLICE_W];
    assign sign_a  = op_a[WIDTH-1];
    assign sign_b  = op_b[WIDTH-1];

    ling8_cin_slice u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            op_is_sub <= 1'b0;
            result    <= '0;
            flag_c    <= 1'b0;
            flag_v    <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_a      <= a;
                        op_b      <= b;
                        op_is_sub <= op_sub;
                        carry     <= op_sub;
                        idx       <= '0;
                        in_ready  <= 1'b0;
                        state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    result[idx*SLICE_W +: SLICE_W] <= slice_sum;
                    carry <= slice_cout;
                    idx   <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        // Final slice supplies the result sign bit directly.
                        flag_c    <= op_is_sub ^ slice_cout;
                        flag_v    <= (sign_a ^ slice_sum[SLICE_W-1]) &
                                     (op_is_sub ? (sign_a ^ sign_b) : ~(sign_a ^ sign_b));
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ling_serial_subtractor.sv
// tb/tb_ling_serial_subtractor.sv - directed self-checking bench for ling_serial_subtractor
module tb_ling_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        op_sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        flag_c;
    logic        flag_v;

    int checks   = 0;
    int failures = 0;

    ling_serial_subtractor #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_c    (flag_c),
        .flag_v    (flag_v)
    );

    always #5 clk = ~clk;

    // Accept at one edge, then wait for out_valid; leaves the bench at the
    // negedge where out_valid was first seen, with out_ready as given.
    task automatic start_and_wait(input logic [31:0] ta, input logic [31:0] tb,
                                  input logic tsub, input logic rdy, output int lat);
        @(negedge clk);
        a         = ta;
        b         = tb;
        op_sub    = tsub;
        in_valid  = 1'b1;
        out_ready = rdy;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a        = 32'hDEAD_BEEF;
        b        = 32'h1234_5678;
        lat      = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string name, input logic [31:0] ta, input logic [31:0] tb,
                          input logic tsub, input logic [31:0] er, input logic ec, input logic ev);
        int lat;
        start_and_wait(ta, tb, tsub, 1'b1, lat);
        checks++;
        if (lat !== 4 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s_latency: got %0d cycles (out_valid=%b), expected 4", name, lat, out_valid);
        end
        checks++;
        if (result !== er) begin
            failures++;
            $display("FAIL %s_result: got %h, expected %h", name, result, er);
        end
        checks++;
        if (flag_c !== ec || flag_v !== ev) begin
            failures++;
            $display("FAIL %s_flags: got c=%b v=%b, expected c=%b v=%b", name, flag_c, flag_v, ec, ev);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_return_idle: got in_ready=%b out_valid=%b, expected 1/0", name, in_ready, out_valid);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        op_sub    = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0 ||
            flag_c !== 1'b0 || flag_v !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got in_ready=%b out_valid=%b result=%h c=%b v=%b, expected 1 0 00000000 0 0",
                     in_ready, out_valid, result, flag_c, flag_v);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_sub();
        run_op("sub_5_3", 32'h0000_0005, 32'h0000_0003, 1'b1, 32'h0000_0002, 1'b0, 1'b0);
        run_op("sub_0_1", 32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_op("sub_min_1", 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1);
        run_op("sub_mixed", 32'h1234_5678, 32'h8765_4321, 1'b1, 32'h8ACF_1357, 1'b1, 1'b1);
    endtask

    task automatic test_add();
        run_op("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        run_op("add_max_1", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        run_op("add_slice_carry", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        int lat;
        int bad = 0;
        start_and_wait(32'h0000_0009, 32'h0000_0004, 1'b1, 1'b0, lat);
        for (int i = 0; i < 10; i++) begin
            a        = 32'h0000_1000 + i;
            b        = 32'h0000_0001;
            in_valid = i[0];
            @(posedge clk);
            @(negedge clk);
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'h0000_0005 ||
                flag_c !== 1'b0 || flag_v !== 1'b0)
                bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL backpressure_hold: %0d of 10 cycles lost the held result (result=%h out_valid=%b in_ready=%b), expected 00000005 1 0",
                     bad, result, out_valid, in_ready);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_release: got in_ready=%b out_valid=%b, expected 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        a         = 32'h1234_5678;
        b         = 32'h0101_0101;
        op_sub    = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if (result[15:0] !== 16'h5577) begin
            failures++;
            $display("FAIL partial_before_reset: got low half %h, expected 5577", result[15:0]);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid_run: got in_ready=%b out_valid=%b result=%h, expected 1 0 00000000",
                     in_ready, out_valid, result);
        end
        @(negedge clk);
        rst = 1'b0;
        run_op("after_reset", 32'h0000_0010, 32'h0000_0001, 1'b1, 32'h0000_000F, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_sub();
        test_add();
        test_backpressure();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
